// File: rtl/ceespu_branch_predictor_pkg.sv
// ceespu_branch_predictor_pkg: 2-bit branch counter encodings shared by the predictor
package ceespu_branch_predictor_pkg;
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;
  localparam logic [1:0] INIT_STATE = WEAK_NT;
endpackage

// File: rtl/ceespu_sat_counter2.sv
// ceespu_sat_counter2: combinational 2-bit saturating increment (taken) / decrement (not taken)
// Ports: i_state current counter, i_taken outcome, o_next updated counter.
module ceespu_sat_counter2
  import ceespu_branch_predictor_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic       i_taken,
  output logic [1:0] o_next
);
  always_comb
    o_next = i_taken ? ((i_state == STRONG_T) ? STRONG_T : i_state + 2'd1)
                     : ((i_state == STRONG_NT) ? STRONG_NT : i_state - 2'd1);
endmodule

// File: rtl/ceespu_branch_predictor.sv
// ceespu_branch_predictor: table of 2-bit saturating counters with registered lookup and write-first update
// Ports: clk, rst (async, active-high); I_instruction lookup source; branch_address,
// branch_prediction_state, branch_taken, update_table update side; prediction_state, prediction outputs.
module ceespu_branch_predictor
  import ceespu_branch_predictor_pkg::*;
#(
  parameter int TABLE_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] I_instruction,
  input  logic [15:0] branch_address,
  input  logic [1:0]  branch_prediction_state,
  input  logic        branch_taken,
  input  logic        update_table,
  output logic [1:0]  prediction_state,
  output logic        prediction
);
  // History is power-up initialised only; rst deliberately leaves it intact.
  logic [1:0] r_table [2**TABLE_BITS] = '{default: INIT_STATE};
  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [TABLE_BITS-1:0] w_rd_idx;
  logic [TABLE_BITS-1:0] w_wr_idx;
  logic w_unused;
  assign w_rd_idx = I_instruction[TABLE_BITS:1];
  assign w_wr_idx = branch_address[TABLE_BITS-1:0];
  assign w_unused = ^{I_instruction[31:TABLE_BITS+1], I_instruction[0], branch_address[15:TABLE_BITS]};
  ceespu_sat_counter2 u_sat (
    .i_state (branch_prediction_state),
    .i_taken (branch_taken),
    .o_next  (w_next)
  );
  always_ff @(posedge clk)
    if (update_table && !rst) r_table[w_wr_idx] <= w_next;
  // Same-cycle update to the looked-up entry forwards the new value.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= INIT_STATE;
    else r_state <= (update_table && w_rd_idx == w_wr_idx) ? w_next : r_table[w_rd_idx];
  assign prediction_state = r_state;
  assign prediction = r_state[1];
endmodule

// File: tb/tb_ceespu_branch_predictor.sv
// tb_ceespu_branch_predictor: scoreboard bench with directed and random stimulus against an array model
module tb_ceespu_branch_predictor;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] I_instruction = 0;
  logic [15:0] branch_address = 0;
  logic [1:0]  branch_prediction_state = 0;
  logic        branch_taken = 0;
  logic        update_table = 0;
  logic [1:0]  prediction_state;
  logic        prediction;
  int checks = 0;
  int errors = 0;
  int model [256];
  int exp_q [$];
  ceespu_branch_predictor dut (
    .clk                     (clk),
    .rst                     (rst),
    .I_instruction           (I_instruction),
    .branch_address          (branch_address),
    .branch_prediction_state (branch_prediction_state),
    .branch_taken            (branch_taken),
    .update_table            (update_table),
    .prediction_state        (prediction_state),
    .prediction              (prediction)
  );
  always #5 clk = ~clk;
  function automatic int sat(int s, bit t);
    return t ? (s == 3 ? 3 : s + 1) : (s == 0 ? 0 : s - 1);
  endfunction
  task automatic step(input logic [31:0] ins, input logic [15:0] addr, input int st, input bit tk, input bit upd);
    int ri, wi, nx, e;
    I_instruction = ins;
    branch_address = addr;
    branch_prediction_state = 2'(st);
    branch_taken = tk;
    update_table = upd;
    ri = int'(ins[8:1]);
    wi = int'(addr[7:0]);
    nx = sat(st, tk);
    e = (upd && ri == wi) ? nx : model[ri];
    if (upd) model[wi] = nx;
    exp_q.push_back(e);
    @(negedge clk);
  endtask
  task automatic check_reset(input string name);
    checks++;
    if (prediction_state !== 2'b01 || prediction !== 1'b0) begin
      errors++;
      $display("FAIL %s: state=%b pred=%b, required state=01 pred=0", name, prediction_state, prediction);
    end
  endtask
  task automatic do_reset(input logic [15:0] addr);
    #1 rst = 1;
    #1 check_reset("async_reset");
    branch_address = addr;
    branch_prediction_state = 2'd2;
    branch_taken = 1;
    update_table = 1;
    @(negedge clk);
    check_reset("reset_hold");
    @(negedge clk);
    rst = 0;
    update_table = 0;
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: output with no expected entry, state=%b", prediction_state);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (prediction_state !== 2'(e) || prediction !== e[1]) begin
          errors++;
          $display("FAIL lookup @%0t: state=%b pred=%b, required state=%b pred=%b", $time, prediction_state, prediction, 2'(e), e[1]);
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 256; i++) model[i] = 1;
    @(negedge clk);
    do_reset(16'd7);
    step(32'hE4140078, 0, 0, 0, 0);
    step(32'hE4140078, 16'd60, 0, 1, 1);
    do_reset(16'd9);
    step(32'hE4140078, 0, 0, 0, 0);
    step(32'h0000000E, 0, 0, 0, 0);
    step(32'h00000012, 0, 0, 0, 0);
    step(0, 16'd5, 3, 1, 1);
    step(32'h0000000A, 0, 0, 0, 0);
    step(0, 16'd5, 0, 0, 1);
    step(32'h0000000A, 0, 0, 0, 0);
    step(0, 16'd5, 2, 0, 1);
    step(32'h0000000A, 0, 0, 0, 0);
    step(32'hE4140078, 16'hFF3C, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(32'h12345678, 16'd60, 3, 1, 0);
    step(32'hE4140078, 0, 0, 0, 0);
    step(32'hFFFFFE79, 16'hAB3C, 2, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      logic [15:0] addr;
      ins = $urandom;
      addr = 16'($urandom);
      if ($urandom_range(0, 1)) begin
        ins[8:1] = 8'($urandom_range(0, 15));
        addr[7:0] = 8'($urandom_range(0, 15));
      end
      step(ins, addr, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
      if (i % 700 == 350) do_reset(16'($urandom));
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
